// File: rtl/priority_encoder_256bit.sv
// priority_encoder_256bit
// Registered 256-bit MSB-first priority encoder. Produces a one-hot grant of
// the highest set request bit plus a valid flag, one cycle after sampling.
// Built as 16 leaf encoders (16 bits each) feeding a 16-way group encoder.
// Optional feature macro: PE_BINARY_IDX_EN adds an 8-bit registered binary
// index output {group[3:0], leaf[3:0]}.

module priority_encoder_256bit (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] in,
    output logic [255:0] out,
`ifdef PE_BINARY_IDX_EN
    output logic [7:0]   idx,
`endif
    output logic         valid
);

    // Per-group leaf results, flattened so each generate instance drives its own slice
    logic [15:0][15:0] leaf_onehot;
    logic [15:0]       group_any;
`ifdef PE_BINARY_IDX_EN
    logic [15:0][3:0]  leaf_idx;
`endif

    // Group-level selection
    logic [15:0]       grp_onehot;
`ifdef PE_BINARY_IDX_EN
    logic [3:0]        grp_idx;
    logic [7:0]        idx_next;
    logic [7:0]        idx_reg;
`endif

    logic [255:0]      out_next;
    logic              valid_next;
    logic [255:0]      out_reg;
    logic              valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_leaf
            logic [15:0] slice;
            logic [15:0] oh;
`ifdef PE_BINARY_IDX_EN
            logic [3:0]  li;
`endif

            assign slice = in[16*gi +: 16];

            // Leaf encoder: ascending scan so the highest set bit overwrites lower ones
            always_comb begin
                oh = '0;
`ifdef PE_BINARY_IDX_EN
                li = '0;
`endif
                for (int b = 0; b < 16; b++) begin
                    if (slice[b]) begin
                        oh    = '0;
                        oh[b] = 1'b1;
`ifdef PE_BINARY_IDX_EN
                        li    = 4'(b);
`endif
                    end
                end
            end

            assign leaf_onehot[gi] = oh;
            assign group_any[gi]   = |slice;
`ifdef PE_BINARY_IDX_EN
            assign leaf_idx[gi]    = li;
`endif
        end
    endgenerate

    // Group encoder: pick the highest-numbered group that has any request
    always_comb begin
        grp_onehot = '0;
`ifdef PE_BINARY_IDX_EN
        grp_idx    = '0;
`endif
        for (int g = 0; g < 16; g++) begin
            if (group_any[g]) begin
                grp_onehot    = '0;
                grp_onehot[g] = 1'b1;
`ifdef PE_BINARY_IDX_EN
                grp_idx       = 4'(g);
`endif
            end
        end
    end

    // Place the winning leaf's one-hot at its slice; every other slice is zero
    generate
        for (gi = 0; gi < 16; gi++) begin : g_place
            assign out_next[16*gi +: 16] = grp_onehot[gi] ? leaf_onehot[gi] : 16'h0000;
        end
    endgenerate

    assign valid_next = |group_any;

`ifdef PE_BINARY_IDX_EN
    // Binary index is the winning group number concatenated with its leaf index
    assign idx_next = {grp_idx, leaf_idx[grp_idx]};
`endif

    // Output registers: single-cycle latency, synchronous clear on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg   <= '0;
            valid_reg <= 1'b0;
`ifdef PE_BINARY_IDX_EN
            idx_reg   <= '0;
`endif
        end else begin
            out_reg   <= out_next;
            valid_reg <= valid_next;
`ifdef PE_BINARY_IDX_EN
            idx_reg   <= idx_next;
`endif
        end
    end

    assign out   = out_reg;
    assign valid = valid_reg;
`ifdef PE_BINARY_IDX_EN
    assign idx   = idx_reg;
`endif

endmodule

// File: tb/tb_priority_encoder_256bit.sv
// tb_priority_encoder_256bit
// Scoreboard bench: each driven input pushes its expected result, which is
// popped and compared one edge later when the registered output is ready.
// Define PE_BINARY_IDX_EN for both bench and RTL to cover the idx port.

module tb_priority_encoder_256bit;

    logic         clk;
    logic         rst;
    logic [255:0] in;
    logic [255:0] out;
    logic         valid;
`ifdef PE_BINARY_IDX_EN
    logic [7:0]   idx;
`endif

    typedef struct {
        logic [255:0] out;
        logic         valid;
        logic [7:0]   idx;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fails;

    priority_encoder_256bit dut (
        .clk   (clk),
        .rst   (rst),
        .in    (in),
        .out   (out),
`ifdef PE_BINARY_IDX_EN
        .idx   (idx),
`endif
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    // Flat reference model: scan from the MSB down, stop at the first set bit
    function automatic exp_t model(input logic r, input logic [255:0] v, input string name);
        exp_t e;
        logic found;
        e.out   = '0;
        e.valid = 1'b0;
        e.idx   = '0;
        e.name  = name;
        found   = 1'b0;
        if (!r) begin
            for (int k = 255; k >= 0; k--) begin
                if (!found && v[k]) begin
                    found    = 1'b1;
                    e.out[k] = 1'b1;
                    e.idx    = 8'(k);
                    e.valid  = 1'b1;
                end
            end
        end
        return e;
    endfunction

    // Pop one expected result and compare it against the current outputs
    task automatic compare_head();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("queue_empty", 256'd0, 256'd1);
            return;
        end
        e = exp_q.pop_front();
        check({e.name, "_out"}, out, e.out);
        check({e.name, "_valid"}, 256'(valid), 256'(e.valid));
        check({e.name, "_onehot"}, 256'($countones(out) <= 1), 256'd1);
`ifdef PE_BINARY_IDX_EN
        check({e.name, "_idx"}, 256'(idx), 256'(e.idx));
        $display("txn %-10s rst=%0b valid=%0b idx=%0d", e.name, rst, valid, idx);
`else
        $display("txn %-10s rst=%0b valid=%0b out=%h", e.name, rst, valid, out);
`endif
    endtask

    // Drive one input for one cycle, then check the result after the edge
    task automatic step(input logic r, input logic [255:0] v, input string name);
        rst = r;
        in  = v;
        exp_q.push_back(model(r, v, name));
        @(posedge clk);
        #1;
        compare_head();
    endtask

    // Drive a value whose expected grant bit is a known constant
    task automatic step_known(input logic [255:0] v, input int bitpos, input string name);
        exp_t e;
        logic [255:0] one;
        one = 256'd1;
        rst = 1'b0;
        in  = v;
        e.out   = one << bitpos;
        e.valid = 1'b1;
        e.idx   = 8'(bitpos);
        e.name  = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare_head();
    endtask

    initial begin
        logic [255:0] ones;
        logic [255:0] r;
        n_checks = 0;
        n_fails  = 0;
        ones     = '1;
        rst      = 1'b1;
        in       = ones;

        // Reset for two edges; input must be ignored
        step(1'b1, ones, "reset0");
        step(1'b1, ones, "reset1");

        // Zero input after release
        step(1'b0, 256'd0, "zero");

        // Back-to-back known vectors, one per cycle
        step_known(256'd4, 2, "in4");
        step_known(256'd9, 3, "in9");
        step_known(256'd23443, 14, "in23443");
        step_known(256'd575875674558, 39, "mid39");
        step_known(256'd7546843688436, 42, "mid42");
        step_known(256'd5854455465457487468658, 72, "mid72");
        step_known(ones, 255, "allones");
        step_known(256'd1, 0, "one");
        step_known(256'd1 << 128, 128, "bit128");
        step(1'b0, 256'd0, "zero2");
        step_known(256'd3 << 15, 16, "grpedge");

        // Reset mid-stream while all-ones is applied, then release
        step_known(ones, 255, "prerst");
        step(1'b1, ones, "midrst");
        step_known(256'd4, 2, "postrst");

        // Random patterns, including sparse ones crossing group boundaries
        for (int t = 0; t < 16; t++) begin
            r = '0;
            for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom;
            if (t % 2 == 1) r = r >> $urandom_range(255, 1);
            step(1'b0, r, $sformatf("rand%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
